// File: rtl/puzzle_core.sv
// Small multi-cycle accumulator-free core: FETCH/EXEC/MEM/HALT FSM with a 2**RAW register file,
// handshake-based instruction and data ports, a registered zero flag and a retired counter.
module puzzle_core #(
   parameter int unsigned DW  = 45,
   parameter int unsigned AW  = 8,
   parameter int unsigned RAW = 6,
   localparam int unsigned IW = 4 + 3 * RAW
) (
   input  logic          clk,
   input  logic          rst,
   output logic          imem_req,
   output logic [AW-1:0] imem_addr,
   input  logic          imem_ack,
   input  logic [IW-1:0] imem_rdata,
   output logic          dmem_req,
   output logic          dmem_we,
   output logic [DW-1:0] dmem_addr,
   output logic [DW-1:0] dmem_wdata,
   input  logic          dmem_ack,
   input  logic [DW-1:0] dmem_rdata,
   output logic [AW-1:0] pc,
   output logic          zf,
   output logic          halted,
   output logic [15:0]   retired
);

   typedef enum logic [1:0] {StFetch, StExec, StMem, StHalt} state_e;

   localparam logic [3:0] OpNop = 4'h0, OpAdd = 4'h1, OpSub = 4'h2, OpAnd = 4'h3;
   localparam logic [3:0] OpOr  = 4'h4, OpXor = 4'h5, OpShl = 4'h6, OpShr = 4'h7;
   localparam logic [3:0] OpLdi = 4'h8, OpLd  = 4'h9, OpSt  = 4'hA, OpJmp = 4'hB;
   localparam logic [3:0] OpJz  = 4'hC, OpJnz = 4'hD, OpCmp = 4'hE, OpHalt = 4'hF;

   state_e          state_q, state_d;
   logic [IW-1:0]   ir_q, ir_d;
   logic [AW-1:0]   pc_q, pc_d, pc_inc, tgt;
   logic            zf_q, zf_d;
   logic [15:0]     ret_q, ret_d;
   logic [DW-1:0]   rf_q [2**RAW];

   logic [3:0]      op;
   logic [RAW-1:0]  dst, src0, src1;
   logic [DW-1:0]   imm, opa, opb, alu;
   logic            rf_we;
   logic [DW-1:0]   rf_wdata;

   assign op     = ir_q[IW-1 -: 4];
   assign dst    = ir_q[3*RAW-1 -: RAW];
   assign src0   = ir_q[2*RAW-1 -: RAW];
   assign src1   = ir_q[RAW-1:0];
   assign imm    = {{(DW - 2*RAW){1'b0}}, ir_q[2*RAW-1:0]};
   assign tgt    = ir_q[AW-1:0];
   assign opa    = rf_q[src0];
   assign opb    = rf_q[src1];
   assign pc_inc = pc_q + AW'(1);

   always_comb begin
      alu = '0;
      unique case (op)
         OpAdd:         alu = opa + opb;
         OpSub, OpCmp:  alu = opa - opb;
         OpAnd:         alu = opa & opb;
         OpOr:          alu = opa | opb;
         OpXor:         alu = opa ^ opb;
         OpShl:         alu = opa << 1;
         OpShr:         alu = opa >> 1;
         default:       alu = '0;
      endcase
   end

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= StFetch;
      else     state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StFetch: if (imem_ack) state_d = StExec;
         StExec: begin
            if (op == OpLd || op == OpSt) state_d = StMem;
            else if (op == OpHalt)        state_d = StHalt;
            else                          state_d = StFetch;
         end
         StMem:   if (dmem_ack) state_d = StFetch;
         default: state_d = StHalt;
      endcase
   end

   // Output logic; requests are gated by rst so an async reset drops them immediately
   always_comb begin
      imem_req   = (state_q == StFetch) && !rst;
      imem_addr  = pc_q;
      dmem_req   = (state_q == StMem) && !rst;
      dmem_we    = (op == OpSt);
      dmem_addr  = opa;
      dmem_wdata = opb;
      halted     = (state_q == StHalt);
      pc         = pc_q;
      zf         = zf_q;
      retired    = ret_q;
   end

   // Datapath next-state
   always_comb begin
      ir_d     = ir_q;
      pc_d     = pc_q;
      zf_d     = zf_q;
      ret_d    = ret_q;
      rf_we    = 1'b0;
      rf_wdata = '0;
      unique case (state_q)
         StFetch: if (imem_ack) ir_d = imem_rdata;
         StExec: begin
            if (op != OpLd && op != OpSt) ret_d = ret_q + 16'd1;
            unique case (op)
               OpAdd, OpSub, OpAnd, OpOr, OpXor, OpShl, OpShr: begin
                  rf_we    = 1'b1;
                  rf_wdata = alu;
                  zf_d     = (alu == '0);
                  pc_d     = pc_inc;
               end
               OpLdi: begin
                  rf_we    = 1'b1;
                  rf_wdata = imm;
                  pc_d     = pc_inc;
               end
               OpCmp: begin
                  zf_d = (alu == '0);
                  pc_d = pc_inc;
               end
               OpJmp:             pc_d = tgt;
               OpJz:              pc_d = zf_q ? tgt : pc_inc;
               OpJnz:             pc_d = zf_q ? pc_inc : tgt;
               OpNop:             pc_d = pc_inc;
               default:           pc_d = pc_q;
            endcase
         end
         StMem: begin
            if (dmem_ack) begin
               pc_d     = pc_inc;
               ret_d    = ret_q + 16'd1;
               rf_we    = (op == OpLd);
               rf_wdata = dmem_rdata;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ir_q  <= '0;
         pc_q  <= '0;
         zf_q  <= 1'b0;
         ret_q <= '0;
      end else begin
         ir_q  <= ir_d;
         pc_q  <= pc_d;
         zf_q  <= zf_d;
         ret_q <= ret_d;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 2**RAW; i++) rf_q[i] <= '0;
      end else if (rf_we) begin
         rf_q[dst] <= rf_wdata;
      end
   end

endmodule

// File: tb/tb_puzzle_core.sv
// Bench for puzzle_core: directed programs plus random programs checked against an ISA-level
// interpreter; memory responders with fixed or random handshake latency.
module tb_puzzle_core;

   localparam int DW = 45, AW = 8, RAW = 6, IW = 22;

   typedef struct {
      logic          we;
      logic [DW-1:0] addr;
      logic [DW-1:0] data;
   } acc_t;

   logic          clk = 1'b0, rst = 1'b1;
   logic          imem_req, imem_ack = 1'b0;
   logic [AW-1:0] imem_addr;
   logic [IW-1:0] imem_rdata = '0;
   logic          dmem_req, dmem_we, dmem_ack = 1'b0;
   logic [DW-1:0] dmem_addr, dmem_wdata, dmem_rdata = '0;
   logic [AW-1:0] pc;
   logic          zf, halted;
   logic [15:0]   retired;

   puzzle_core #(.DW(DW), .AW(AW), .RAW(RAW)) dut (
      .clk(clk), .rst(rst),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
      .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
      .pc(pc), .zf(zf), .halted(halted), .retired(retired)
   );

   initial forever #5 clk = ~clk;

   int vectors = 0, fails = 0;
   int idelay = 0, ddelay = 0;  // -1 selects random latency per access
   bit spur = 1'b0;
   logic [IW-1:0] imem [256];
   logic [DW-1:0] dmem [logic [DW-1:0]];
   acc_t obs_q[$], exp_q[$];
   logic [AW-1:0] exp_pc;
   logic          exp_zf;
   logic [15:0]   exp_ret;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vectors++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [IW-1:0] ins(input int op, input int d, input int s0, input int s1);
      return {op[3:0], d[5:0], s0[5:0], s1[5:0]};
   endfunction

   function automatic logic [IW-1:0] insi(input int op, input int d, input int im);
      return {op[3:0], d[5:0], im[11:0]};
   endfunction

   // Instruction memory responder
   initial begin
      int cnt = 0;
      bit busy = 1'b0;
      logic [AW-1:0] a0 = '0;
      forever begin
         @(negedge clk);
         if (imem_req) begin
            if (!busy) begin
               busy = 1'b1;
               cnt  = (idelay < 0) ? int'($urandom_range(0, 3)) : idelay;
               a0   = imem_addr;
            end else begin
               check("imem_addr_stable", 64'(imem_addr), 64'(a0));
            end
            if (cnt == 0) begin
               imem_ack   = 1'b1;
               imem_rdata = imem[imem_addr];
               busy       = 1'b0;
            end else begin
               imem_ack = 1'b0;
               cnt--;
            end
         end else begin
            busy       = 1'b0;
            imem_ack   = spur ? 1'($urandom_range(0, 1)) : 1'b0;
            imem_rdata = IW'($urandom);
         end
      end
   end

   // Data memory responder; an access is logged when its ack is presented
   initial begin
      int cnt = 0;
      bit busy = 1'b0;
      acc_t a0;
      a0 = '{1'b0, '0, '0};
      forever begin
         @(negedge clk);
         if (dmem_req) begin
            if (!busy) begin
               busy = 1'b1;
               cnt  = (ddelay < 0) ? int'($urandom_range(0, 3)) : ddelay;
               a0   = '{dmem_we, dmem_addr, dmem_wdata};
            end else begin
               check("dmem_we_stable", 64'(dmem_we), 64'(a0.we));
               check("dmem_addr_stable", 64'(dmem_addr), 64'(a0.addr));
               check("dmem_wdata_stable", 64'(dmem_wdata), 64'(a0.data));
            end
            if (cnt == 0) begin
               dmem_ack = 1'b1;
               busy     = 1'b0;
               if (dmem_we) begin
                  dmem[dmem_addr] = dmem_wdata;
                  obs_q.push_back('{1'b1, dmem_addr, dmem_wdata});
               end else begin
                  dmem_rdata = dmem.exists(dmem_addr) ? dmem[dmem_addr] : '0;
                  obs_q.push_back('{1'b0, dmem_addr, dmem_rdata});
               end
            end else begin
               dmem_ack = 1'b0;
               cnt--;
            end
         end else begin
            busy       = 1'b0;
            dmem_ack   = spur ? 1'($urandom_range(0, 1)) : 1'b0;
            dmem_rdata = {$urandom, $urandom};
         end
      end
   end

   // ISA interpreter: runs the program in imem to HALT from a reset state
   task automatic model_run();
      logic [DW-1:0] r [64];
      logic [DW-1:0] mm [logic [DW-1:0]];
      logic [DW-1:0] a, b, res, v;
      logic [IW-1:0] w;
      logic [3:0]    op;
      logic [AW-1:0] p = '0;
      logic          z = 1'b0;
      logic [15:0]   n = '0;
      exp_q.delete();
      foreach (r[i]) r[i] = '0;
      for (int step = 0; step < 5000; step++) begin
         w  = imem[p];
         op = w[21:18];
         a  = r[w[11:6]];
         b  = r[w[5:0]];
         n  = n + 16'd1;
         if (op == 4'hF) break;
         case (op)
            4'h1: res = a + b;
            4'h2, 4'hE: res = a - b;
            4'h3: res = a & b;
            4'h4: res = a | b;
            4'h5: res = a ^ b;
            4'h6: res = a << 1;
            4'h7: res = a >> 1;
            default: res = '0;
         endcase
         if (op >= 4'h1 && op <= 4'h7) begin
            r[w[17:12]] = res;
            z = (res == '0);
         end
         if (op == 4'hE) z = (res == '0);
         if (op == 4'h8) r[w[17:12]] = DW'(w[11:0]);
         if (op == 4'h9) begin
            v = mm.exists(a) ? mm[a] : '0;
            r[w[17:12]] = v;
            exp_q.push_back('{1'b0, a, v});
         end
         if (op == 4'hA) begin
            mm[a] = b;
            exp_q.push_back('{1'b1, a, b});
         end
         if (op == 4'hB) p = w[7:0];
         else if (op == 4'hC) p = z ? w[7:0] : p + 8'd1;
         else if (op == 4'hD) p = z ? p + 8'd1 : w[7:0];
         else p = p + 8'd1;
      end
      exp_pc  = p;
      exp_zf  = z;
      exp_ret = n;
   endtask

   task automatic clear_imem();
      foreach (imem[i]) imem[i] = insi(15, 0, 0);
   endtask

   // Reset for two edges, release just after a rising edge so the next edge takes a 0-wait ack
   task automatic start(input int id, input int dd);
      rst    = 1'b1;
      idelay = id;
      ddelay = dd;
      repeat (2) @(posedge clk);
      obs_q.delete();
      dmem.delete();
      #2 rst = 1'b0;
      #1;
      check("first_fetch_req", 64'(imem_req), 64'd1);
      check("first_fetch_addr", 64'(imem_addr), 64'd0);
   endtask

   task automatic run_to_halt();
      int n = 0;
      while (!halted && n < 3000) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("halt_reached", 64'(halted), 64'd1);
   endtask

   task automatic compare_model(input string tag);
      model_run();
      check({tag, "_pc"}, 64'(pc), 64'(exp_pc));
      check({tag, "_zf"}, 64'(zf), 64'(exp_zf));
      check({tag, "_retired"}, 64'(retired), 64'(exp_ret));
      check({tag, "_nacc"}, 64'(obs_q.size()), 64'(exp_q.size()));
      for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
         check({tag, "_acc_we"}, 64'(obs_q[i].we), 64'(exp_q[i].we));
         check({tag, "_acc_addr"}, 64'(obs_q[i].addr), 64'(exp_q[i].addr));
         check({tag, "_acc_data"}, 64'(obs_q[i].data), 64'(exp_q[i].data));
      end
   endtask

   initial begin
      int len, op, tg;
      logic [AW-1:0] hpc;
      logic [15:0]   hret;
      int            nacc;

      // Reset state
      #3;
      check("rst_imem_req", 64'(imem_req), 64'd0);
      check("rst_dmem_req", 64'(dmem_req), 64'd0);
      check("rst_pc", 64'(pc), 64'd0);
      check("rst_zf", 64'(zf), 64'd0);
      check("rst_halted", 64'(halted), 64'd0);
      check("rst_retired", 64'(retired), 64'd0);

      // LDI/LDI/SUB/JZ with zero-wait fetch
      clear_imem();
      imem[0]    = insi(8, 1, 5);
      imem[1]    = insi(8, 2, 5);
      imem[2]    = ins(2, 3, 1, 2);
      imem[3]    = insi(12, 0, 'h10);
      imem['h10] = ins(10, 0, 0, 3);
      start(0, 0);
      repeat (8) @(posedge clk);
      #1;
      check("jz_pc", 64'(pc), 64'h10);
      check("jz_retired", 64'(retired), 64'd4);
      check("jz_zf", 64'(zf), 64'd1);
      run_to_halt();
      compare_model("jz");
      check("jz_r3_stored", 64'(obs_q.size() > 0 ? obs_q[0].data : 45'h1), 64'd0);

      // Fetch ack delayed by 3 cycles
      clear_imem();
      imem[0] = insi(8, 1, 'h55);
      start(3, 0);
      for (int k = 0; k < 3; k++) begin
         @(posedge clk);
         #1;
         check("wait_imem_req", 64'(imem_req), 64'd1);
         check("wait_imem_addr", 64'(imem_addr), 64'd0);
         check("wait_retired", 64'(retired), 64'd0);
      end
      @(posedge clk);
      #1;
      check("acked_imem_req", 64'(imem_req), 64'd0);
      check("acked_retired", 64'(retired), 64'd0);
      @(posedge clk);
      #1;
      check("one_retired", 64'(retired), 64'd1);
      check("one_pc", 64'(pc), 64'd1);

      // Store then load through a 2-cycle data memory; LD must not disturb zf
      clear_imem();
      imem[0]    = insi(8, 1, 7);
      imem[1]    = insi(8, 2, 'h91A);
      imem[2]    = ins(6, 2, 2, 0);
      imem[3]    = ins(10, 0, 1, 2);
      imem[4]    = ins(14, 0, 0, 0);
      imem[5]    = ins(9, 4, 1, 0);
      imem[6]    = insi(12, 0, 'h20);
      imem['h20] = ins(10, 0, 0, 4);
      start(0, 2);
      run_to_halt();
      compare_model("ldst");
      check("ldst_zf_kept", 64'(zf), 64'd1);
      check("ldst_final_pc", 64'(pc), 64'h21);
      check("ldst_r4", 64'(obs_q.size() == 3 ? obs_q[2].data : '0), 64'h1234);

      // PC wraps from 0xFF to 0x00
      clear_imem();
      imem[0]    = insi(11, 0, 'hFF);
      imem['hFF] = insi(0, 0, 0);
      start(0, 0);
      repeat (4) @(posedge clk);
      #1;
      check("wrap_pc", 64'(pc), 64'd0);
      check("wrap_fetch_addr", 64'(imem_addr), 64'd0);
      check("wrap_fetch_req", 64'(imem_req), 64'd1);
      check("wrap_retired", 64'(retired), 64'd2);

      // Reset in the middle of a data access
      clear_imem();
      imem[0] = insi(8, 1, 9);
      imem[1] = insi(8, 2, 3);
      imem[2] = ins(10, 0, 1, 2);
      start(0, 50);
      begin
         int n = 0;
         while (!dmem_req && n < 40) begin
            @(posedge clk);
            #1;
            n++;
         end
      end
      check("mem_req_seen", 64'(dmem_req), 64'd1);
      #2 rst = 1'b1;
      #1;
      check("rstmem_dmem_req", 64'(dmem_req), 64'd0);
      check("rstmem_imem_req", 64'(imem_req), 64'd0);
      check("rstmem_pc", 64'(pc), 64'd0);
      check("rstmem_retired", 64'(retired), 64'd0);
      clear_imem();
      imem[0] = ins(10, 0, 1, 2);
      start(0, 1);
      run_to_halt();
      compare_model("rstmem");

      // Random programs with forward-only control flow and random latencies
      for (int t = 0; t < 6; t++) begin
         clear_imem();
         len = $urandom_range(8, 40);
         for (int i = 0; i < len - 1; i++) begin
            op = $urandom_range(0, 14);
            tg = $urandom_range(i + 1, len - 1);
            if (op >= 11 && op <= 13) imem[i] = insi(op, 0, tg);
            else if (op == 8)         imem[i] = insi(8, $urandom_range(0, 7), $urandom_range(0, 4095));
            else imem[i] = ins(op, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
         end
         start(-1, -1);
         run_to_halt();
         compare_model("rand");
      end

      // Spurious acks while halted
      hpc  = pc;
      hret = retired;
      nacc = obs_q.size();
      spur = 1'b1;
      for (int k = 0; k < 10; k++) begin
         @(posedge clk);
         #1;
         check("halt_halted", 64'(halted), 64'd1);
         check("halt_pc", 64'(pc), 64'(hpc));
         check("halt_retired", 64'(retired), 64'(hret));
         check("halt_imem_req", 64'(imem_req), 64'd0);
         check("halt_dmem_req", 64'(dmem_req), 64'd0);
      end
      check("halt_no_access", 64'(obs_q.size()), 64'(nacc));
      spur = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
      $finish;
   end

endmodule

// File: doc/puzzle_core.md
PUZZLE_CORE -- requirements
Module: puzzle_core

Interface
REQ-001 Parameters SHALL be as listed below, one per line (name, default, meaning).
- DW, 45, data/register width; SHALL be >= 2*RAW.
- AW, 8, PC and instruction-address width.
- RAW, 6, register-address width; register file holds 2**RAW entries.
REQ-002 Instruction width SHALL be IW = 4+3*RAW, with fields:
- [IW-1:IW-4] opcode
- next RAW bits dst
- next RAW bits src0
- low RAW bits src1
- imm = {src0,src1}, zero-extended.
REQ-003 Ports SHALL be as listed below, one per line (name, direction, width, meaning).
- clk  in  1  single clock; all state on rising edge.
- rst  in  1  asynchronous active-high reset.
- imem_req  out  1  instruction fetch request.
- imem_addr  out  AW  fetch address (= pc).
- imem_ack  in  1  fetch complete; imem_rdata valid this cycle.
- imem_rdata  in  IW  instruction word.
- dmem_req  out  1  data access request.
- dmem_we  out  1  1 = store, 0 = load.
- dmem_addr  out  DW  data address (= R[src0]).
- dmem_wdata  out  DW  store data (= R[src1]).
- dmem_ack  in  1  access complete; dmem_rdata valid this cycle for loads.
- dmem_rdata  in  DW  load data.
- pc  out  AW  current program counter.
- zf  out  1  registered zero flag.
- halted  out  1  core in HALT state.
- retired  out  16  retired-instruction counter.

Function
REQ-004 The FSM SHALL have states FETCH, EXEC, MEM and HALT.
REQ-005 In FETCH, imem_req SHALL be 1 with imem_addr = pc, held stable until the imem_ack cycle; on ack, latch the instruction and go to EXEC.
REQ-006 EXEC SHALL last one cycle; opcode behaviour:
- 0 NOP
- 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR, 6 SHL1 (src0<<1), 7 SHR1 (src0>>1): R[dst] = result; ALU ops use src0 and src1 for two-operand forms.
- 8 LDI: R[dst] = imm.
- 9 LD, A ST: go to MEM.
- B JMP: pc = imm[AW-1:0].
- C JZ, D JNZ: branch to imm[AW-1:0] if zf == 1 / zf == 0, else pc+1.
- E CMP: flags only, from src0-src1.
- F HALT.
REQ-007 zf SHALL be updated to (result == 0) by opcodes 1-7 and E only; all other opcodes leave zf unchanged.
REQ-008 JZ/JNZ SHALL test the zf value registered before the current instruction.
REQ-009 Arithmetic SHALL be modulo 2**DW; there are no carry or overflow flags.
REQ-010 Non-jump, non-memory opcodes SHALL set pc = pc+1 modulo 2**AW and return to FETCH; 2**AW-1 SHALL wrap to 0.
REQ-011 In MEM, dmem_req SHALL be held with stable addr/we/wdata until the dmem_ack cycle.
- LD writes R[dst] = dmem_rdata on the ack edge.
- Both LD and ST then set pc+1 and go to FETCH.
REQ-012 imem_ack outside FETCH and dmem_ack outside MEM SHALL be ignored.
REQ-013 Register reads SHALL be asynchronous; a write to R[dst] SHALL be visible to the next instruction.
REQ-014 HALT SHALL stall with all requests 0, pc frozen and halted = 1 until reset.
REQ-015 retired SHALL increment (wrapping) on the last cycle of every completed instruction, including HALT once on entry.
REQ-016 Minimum CPI SHALL be 2 (FETCH with same-cycle ack, then EXEC); LD/ST minimum CPI SHALL be 3.

Reset
REQ-017 rst SHALL asynchronously force state = FETCH, pc = 0, zf = 0, halted = 0, retired = 0, all registers = 0 and the instruction latch = NOP.
REQ-018 Reset asserted mid-FETCH or mid-MEM SHALL drop imem_req/dmem_req in the same cycle; the pending access is discarded.
REQ-019 After rst deassertion, the first rising edge SHALL see imem_req = 1 with imem_addr = 0.

Verification
REQ-020 LDI R1,5; LDI R2,5; SUB R3,R1,R2; JZ 0x10 with zero-wait ack -> R3 = 0, zf = 1, pc = 0x10, retired = 4 after 8 cycles.
REQ-021 imem_ack delayed 3 cycles -> imem_addr stable for 4 cycles, exactly one instruction executed.
REQ-022 ST R[src0]=7 data R[src1]=0x1234, then LD R4 from addr 7 against a simple memory model with 2-cycle dmem_ack -> R4 = 0x1234; zf unchanged by the LD.
REQ-023 JMP 0xFF, then NOP at 0xFF -> next fetch address 0x00 (wrap).
REQ-024 rst pulsed during MEM with dmem_req = 1 -> dmem_req = 0 the same cycle, pc = 0 and registers = 0 afterwards.
REQ-025 HALT followed by spurious imem_ack/dmem_ack -> halted stays 1, pc and retired frozen, no requests issued.
